// File: rtl/irq_queue_ctrl.sv
// irq_queue_ctrl: edge-detecting interrupt collector feeding a DEPTH-entry ID FIFO,
// with a two-state dispatcher that presents one ID to the core until eoi.
// Optional build macro IRQ_FIXED_PRIO_EN: scanner always picks the lowest-indexed
// pending source instead of round-robin (the scan pointer is then not built).
module irq_queue_ctrl #(
   parameter int NSRC  = 7,
   parameter int IDW   = 3,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NSRC-1:0]            irq_in,
   input  logic [NSRC-1:0]            mask,
   input  logic                       eoi,
   output logic                       irq_valid,
   output logic [IDW-1:0]             irq_id,
   output logic [NSRC-1:0]            pending,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Edge detection, pending and overflow state
   logic [NSRC-1:0] s_in_q, prev_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic            overflow_q, overflow_d;
   logic [NSRC-1:0] rise, set_req, push_mask;

   // Scanner
   logic            push_hit, push_do;
   logic [IDW-1:0]  push_idx, push_id;

   // FIFO
   logic [IDW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [IDW-1:0]  head;

   // Dispatcher
   state_t          state_q, state_d;
   logic [IDW-1:0]  irq_id_q, irq_id_d;
   logic            pop_do;

   assign rise      = s_in_q & ~prev_q;
   assign set_req   = rise & ~mask;
   assign push_mask = push_do ? (NSRC'(1) << push_idx) : '0;
   assign push_id   = push_idx + 1'b1;
   assign head      = mem_q[rd_ptr_q];

`ifdef IRQ_FIXED_PRIO_EN
   // Fixed priority: lowest-indexed pending source wins
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      push_hit = 1'b0;
      push_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            push_hit = 1'b1;
            push_idx = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] ptr_q, ptr_d;

   // Round-robin: first pending source at or after ptr, wrapping modulo NSRC
   always_comb begin
      logic [IDW:0] cand;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      push_hit = 1'b0;
      push_idx = '0;
      cand     = '0;
      for (int i = 0; i < NSRC; i++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(NSRC)) cand = cand - (IDW+1)'(NSRC);
         if (!push_hit && pending_q[cand[IDW-1:0]]) begin
            push_hit = 1'b1;
            push_idx = cand[IDW-1:0];
         end
      end
   end

   // Pointer moves past the source just pushed, otherwise holds
   always_comb begin
      ptr_d = ptr_q;
      if (push_do) ptr_d = (push_idx == IDW'(NSRC - 1)) ? '0 : push_idx + 1'b1;
   end

   // Scan pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   // A push is allowed when there is room, or when a pop frees a slot this cycle
   assign push_do = push_hit && ((count_q != FULL_CNT) || pop_do);

   // Pending/overflow next state: a new rise beats the clear from a push
   always_comb begin
      pending_d  = (pending_q & ~push_mask) | set_req;
      overflow_d = overflow_q | (|(set_req & pending_q & ~push_mask));
   end

   // Input synchroniser stage, edge history, pending and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         s_in_q     <= '0;
         prev_q     <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         s_in_q     <= irq_in;
         prev_q     <= s_in_q;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO occupancy: simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      case ({push_do, pop_do})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_do) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_do)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; entries are only read after being written, tracked by count_q.
      if (push_do) mem_q[wr_ptr_q] <= push_id;
   end

   // Dispatcher next state: pop in IDLE when non-empty, back-to-back pop on eoi in BUSY
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      pop_do   = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop_do   = 1'b1;
               irq_id_d = head;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (eoi) begin
               if (count_q != '0) begin
                  pop_do   = 1'b1;
                  irq_id_d = head;
               end else begin
                  irq_id_d = '0;
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            irq_id_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   // Dispatcher state and presented ID
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         irq_id_q <= '0;
      end else begin
         state_q  <= state_d;
         irq_id_q <= irq_id_d;
      end
   end

   assign irq_valid = (state_q == BUSY);
   assign irq_id    = irq_id_q;
   assign pending   = pending_q;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_queue_ctrl.sv
// Testbench for irq_queue_ctrl: instance A uses DEPTH=16, instance B uses DEPTH=4
// for the full-queue and overflow scenarios. Expected IDs go into a queue when the
// lines are driven and are popped as the dispatcher presents them.
module tb_irq_queue_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic [6:0] irq_a, mask_a;
   logic       eoi_a;
   logic       valid_a;
   logic [2:0] id_a;
   logic [6:0] pend_a;
   logic [4:0] cnt_a;
   logic       ovf_a;

   logic [6:0] irq_b, mask_b;
   logic       eoi_b;
   logic       valid_b;
   logic [2:0] id_b;
   logic [6:0] pend_b;
   logic [2:0] cnt_b;
   logic       ovf_b;

   int errors = 0;
   int checks = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   irq_queue_ctrl #(.NSRC(7), .IDW(3), .DEPTH(16)) dut_a (
      .clk(clk), .rst(rst), .irq_in(irq_a), .mask(mask_a), .eoi(eoi_a),
      .irq_valid(valid_a), .irq_id(id_a), .pending(pend_a), .count(cnt_a),
      .overflow(ovf_a)
   );

   irq_queue_ctrl #(.NSRC(7), .IDW(3), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .irq_in(irq_b), .mask(mask_b), .eoi(eoi_b),
      .irq_valid(valid_b), .irq_id(id_b), .pending(pend_b), .count(cnt_b),
      .overflow(ovf_b)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic reset_all();
      rst    = 1'b1;
      irq_a  = '0; mask_a = '0; eoi_a = 1'b0;
      irq_b  = '0; mask_b = '0; eoi_b = 1'b0;
      exp_q.delete();
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      irq_a = '0; mask_a = '0; eoi_a = 1'b0;
      irq_b = '0; mask_b = '0; eoi_b = 1'b0;
      step(); step();
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      checks++; if (id_a !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", id_a); end
      checks++; if (pend_a !== 7'd0) begin errors++; $display("FAIL reset_pending got=%h exp=0", pend_a); end
      checks++; if (cnt_a !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
      checks++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b%b exp=00", ovf_a, ovf_b); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_source();
      int lat;
      reset_all();
      irq_a = 7'b0000100;
      exp_q.push_back(3);
      step();
      irq_a = '0;
      lat = 1;
      while (!valid_a && lat < 10) begin step(); lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", lat); end
      checks++; if (id_a !== 3'(exp_q.pop_front())) begin errors++; $display("FAIL single_id got=%0d exp=3", id_a); end
      eoi_a = 1'b1; step(); eoi_a = 1'b0;
      checks++; if (valid_a !== 1'b0 || id_a !== 3'd0) begin errors++; $display("FAIL single_eoi got=%b/%0d exp=0/0", valid_a, id_a); end
   endtask

   task automatic test_round_robin();
      logic [6:0] exp_p;
      int         exp_id;
      reset_all();
      irq_a = 7'h7F;
      for (int i = 1; i <= 7; i++) exp_q.push_back(i);
      step();
      for (int c = 0; c < 8; c++) begin
         step();
         exp_p = 7'h7F << c;
         checks++; if (pend_a !== exp_p) begin errors++; $display("FAIL rr_pending cyc=%0d got=%h exp=%h", c, pend_a, exp_p); end
      end
      checks++; if (cnt_a !== 5'd6) begin errors++; $display("FAIL rr_count got=%0d exp=6", cnt_a); end
      for (int n = 0; n < 7; n++) begin
         exp_id = exp_q.pop_front();
         checks++; if (valid_a !== 1'b1 || id_a !== 3'(exp_id)) begin errors++; $display("FAIL rr_order n=%0d got=%b/%0d exp=1/%0d", n, valid_a, id_a, exp_id); end
         eoi_a = 1'b1; step(); eoi_a = 1'b0;
      end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", valid_a); end
   endtask

   task automatic test_back_to_back();
      int n;
      int exp_id;
      reset_all();
      irq_a = 7'b0011000;
      exp_q.push_back(4);
      exp_q.push_back(5);
      n = 0;
      while (!valid_a && n < 10) begin step(); n++; end
      exp_id = exp_q.pop_front();
      checks++; if (valid_a !== 1'b1 || id_a !== 3'(exp_id)) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=1/%0d", valid_a, id_a, exp_id); end
      eoi_a = 1'b1; step(); eoi_a = 1'b0;
      exp_id = exp_q.pop_front();
      checks++; if (valid_a !== 1'b1 || id_a !== 3'(exp_id)) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=1/%0d", valid_a, id_a, exp_id); end
      eoi_a = 1'b1; step(); eoi_a = 1'b0;
      checks++; if (valid_a !== 1'b0 || id_a !== 3'd0) begin errors++; $display("FAIL b2b_idle got=%b/%0d exp=0/0", valid_a, id_a); end
   endtask

   task automatic test_full_fifo();
      int n;
      int exp_id;
      reset_all();
      irq_b = 7'b0111111;
      for (int i = 1; i <= 6; i++) exp_q.push_back(i);
      repeat (12) step();
      checks++; if (cnt_b !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", cnt_b); end
      checks++; if (pend_b !== 7'h20) begin errors++; $display("FAIL full_pending got=%h exp=20", pend_b); end
      exp_id = exp_q.pop_front();
      checks++; if (valid_b !== 1'b1 || id_b !== 3'(exp_id)) begin errors++; $display("FAIL full_head got=%b/%0d exp=1/%0d", valid_b, id_b, exp_id); end
      eoi_b = 1'b1; step(); eoi_b = 1'b0;
      n = 1;
      while (pend_b[5] && n < 2) begin step(); n++; end
      checks++; if (pend_b !== 7'h00) begin errors++; $display("FAIL full_drain_pending got=%h exp=00", pend_b); end
      checks++; if (cnt_b !== 3'd4) begin errors++; $display("FAIL full_refill_count got=%0d exp=4", cnt_b); end
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         exp_id = exp_q.pop_front();
         checks++; if (valid_b !== 1'b1 || id_b !== 3'(exp_id)) begin errors++; $display("FAIL full_order got=%b/%0d exp=1/%0d", valid_b, id_b, exp_id); end
         eoi_b = 1'b1; step(); eoi_b = 1'b0;
         n++;
      end
      checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL full_idle got=%b exp=0", valid_b); end
   endtask

   task automatic test_mask_overflow();
      int exp_id;
      reset_all();
      mask_b = 7'b0000001;
      irq_b  = 7'b0000001;
      step();
      irq_b  = '0;
      repeat (5) step();
      checks++; if (pend_b !== 7'd0 || valid_b !== 1'b0) begin errors++; $display("FAIL mask_blocks got=%h/%b exp=00/0", pend_b, valid_b); end
      irq_b = 7'b0111110;
      for (int i = 2; i <= 6; i++) exp_q.push_back(i);
      repeat (12) step();
      checks++; if (cnt_b !== 3'd4) begin errors++; $display("FAIL ovf_full_count got=%0d exp=4", cnt_b); end
      exp_id = exp_q.pop_front();
      checks++; if (id_b !== 3'(exp_id)) begin errors++; $display("FAIL ovf_head got=%0d exp=%0d", id_b, exp_id); end
      mask_b = '0;
      irq_b  = 7'b0111111;
      repeat (3) step();
      checks++; if (pend_b !== 7'h01 || ovf_b !== 1'b0) begin errors++; $display("FAIL unmask_pending got=%h/%b exp=01/0", pend_b, ovf_b); end
      irq_b = 7'b0111110;
      step();
      irq_b = 7'b0111111;
      repeat (3) step();
      checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_b); end
      eoi_b = 1'b1; step(); eoi_b = 1'b0;
      repeat (3) step();
      checks++; if (ovf_b !== 1'b1 || pend_b !== 7'h00) begin errors++; $display("FAIL ovf_sticky got=%b/%h exp=1/00", ovf_b, pend_b); end
      checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_isolated got=%b exp=0", ovf_a); end
   endtask

   task automatic test_reset_mid();
      reset_all();
      irq_a = 7'b0001111;
      repeat (10) step();
      checks++; if (valid_a !== 1'b1 || cnt_a !== 5'd3) begin errors++; $display("FAIL mid_busy got=%b/%0d exp=1/3", valid_a, cnt_a); end
      #2 rst = 1'b1;
      #1;
      checks++; if (valid_a !== 1'b0 || id_a !== 3'd0) begin errors++; $display("FAIL mid_rst_out got=%b/%0d exp=0/0", valid_a, id_a); end
      checks++; if (cnt_a !== 5'd0 || pend_a !== 7'd0) begin errors++; $display("FAIL mid_rst_state got=%0d/%h exp=0/00", cnt_a, pend_a); end
      checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf_b); end
      irq_a = '0;
      irq_b = '0;
      step(); step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         checks++; if (valid_a !== 1'b0 || cnt_a !== 5'd0) begin errors++; $display("FAIL mid_no_replay cyc=%0d got=%b/%0d exp=0/0", c, valid_a, cnt_a); end
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_back_to_back();
      test_full_fifo();
      test_mask_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
